// File: rtl/dma_read_arbiter.sv
// dma_read_arbiter
//   Shares one DMA read channel between NUM_CLIENTS engines. The arbitration
//   is round-robin. A grant is combinational and lands in a registered output
//   stage. Each forwarded burst records {client, len} in an in-order tag FIFO.
//   Returning lines are steered to the owner of the head tag with no added
//   latency.
//
//   Handshake rule on every channel: a transfer happens on a rising clk edge
//   where valid and ready are both 1. The source keeps its payload stable
//   while valid is high and ready is low.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   req_valid/ready   per-client request handshake (ready is one-hot grant)
//   req_addr/len      packed per-client address/length, client i at slice i
//   dma_rd_*          forwarded request to the DMA read adapter
//   dma_rdata_*       returned cache lines from the DMA adapter
//   rsp_valid/ready   per-client line handshake (valid one-hot on owner)
//   rsp_data/last     shared line data, last-line-of-burst flag
//   busy              request held in output stage or any burst outstanding
module dma_read_arbiter #(
  parameter int NUM_CLIENTS = 4,
  parameter int ADDR_WIDTH  = 64,
  parameter int LEN_WIDTH   = 32,
  parameter int DATA_WIDTH  = 512,
  parameter int TAG_DEPTH   = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CLIENTS-1:0]            req_valid,
  output logic [NUM_CLIENTS-1:0]            req_ready,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_CLIENTS*LEN_WIDTH-1:0]  req_len,
  output logic                              dma_rd_valid,
  input  logic                              dma_rd_ready,
  output logic [ADDR_WIDTH-1:0]             dma_rd_addr,
  output logic [LEN_WIDTH-1:0]              dma_rd_len,
  input  logic                              dma_rdata_valid,
  output logic                              dma_rdata_ready,
  input  logic [DATA_WIDTH-1:0]             dma_rdata,
  output logic [NUM_CLIENTS-1:0]            rsp_valid,
  input  logic [NUM_CLIENTS-1:0]            rsp_ready,
  output logic [DATA_WIDTH-1:0]             rsp_data,
  output logic                              rsp_last,
  output logic                              busy
);

  localparam int CW   = $clog2(NUM_CLIENTS);
  localparam int AW   = $clog2(TAG_DEPTH);
  localparam int CNTW = AW + 1;

  // Request output stage and arbitration pointer
  logic [CW-1:0]         r_rr_ptr;
  logic                  r_rd_valid;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [LEN_WIDTH-1:0]  r_rd_len;

  // Tag FIFO storage and pointers
  logic [CW-1:0]         r_tag_id  [TAG_DEPTH];
  logic [LEN_WIDTH-1:0]  r_tag_len [TAG_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CNTW-1:0]       r_count;
  logic [LEN_WIDTH-1:0]  r_beat;

  logic [CW-1:0]         w_winner;
  logic                  w_found;
  logic [CW-1:0]         w_rr_next;
  logic                  w_out_free;
  logic                  w_fifo_full;
  logic                  w_fifo_ne;
  logic                  w_grant;
  logic [ADDR_WIDTH-1:0] w_grant_addr;
  logic [LEN_WIDTH-1:0]  w_grant_len;
  logic                  w_push;
  logic [CW-1:0]         w_head_id;
  logic [LEN_WIDTH-1:0]  w_head_len;
  logic                  w_head_last;
  logic                  w_accept;
  logic                  w_pop;

  // First asserted request at or after r_rr_ptr, scanning cyclically
  always_comb begin : p_arb
    int idx;
    idx      = 0;
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_CLIENTS) idx = idx - NUM_CLIENTS;
      if (!w_found && req_valid[idx]) begin
        w_found  = 1'b1;
        w_winner = CW'(idx);
      end
    end
  end

  assign w_rr_next    = (w_winner == CW'(NUM_CLIENTS - 1)) ? '0 : w_winner + CW'(1);
  assign w_out_free   = !r_rd_valid || dma_rd_ready;
  assign w_fifo_full  = (r_count == CNTW'(TAG_DEPTH));
  assign w_fifo_ne    = (r_count != '0);
  assign w_grant      = !reset && w_out_free && !w_fifo_full && w_found;
  assign w_grant_addr = req_addr[w_winner*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_grant_len  = req_len[w_winner*LEN_WIDTH +: LEN_WIDTH];
  // Zero-length requests are consumed but never forwarded or tagged
  assign w_push       = w_grant && (w_grant_len != '0);

  assign w_head_id    = r_tag_id[r_rd_ptr];
  assign w_head_len   = r_tag_len[r_rd_ptr];
  assign w_head_last  = (r_beat == w_head_len - LEN_WIDTH'(1));
  // Data with an empty FIFO is never acknowledged
  assign w_accept     = !reset && w_fifo_ne && dma_rdata_valid && rsp_ready[w_head_id];
  assign w_pop        = w_accept && w_head_last;

  always_comb begin
    req_ready = '0;
    if (w_grant) req_ready[w_winner] = 1'b1;
  end

  always_comb begin
    rsp_valid = '0;
    if (!reset && w_fifo_ne && dma_rdata_valid) rsp_valid[w_head_id] = 1'b1;
  end

  assign dma_rdata_ready = !reset && w_fifo_ne && rsp_ready[w_head_id];
  assign rsp_data        = dma_rdata;
  assign rsp_last        = !reset && w_fifo_ne && w_head_last;
  assign dma_rd_valid    = r_rd_valid;
  assign dma_rd_addr     = r_rd_addr;
  assign dma_rd_len      = r_rd_len;
  assign busy            = r_rd_valid || w_fifo_ne;

  // Request output stage and round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr   <= '0;
      r_rd_valid <= 1'b0;
      r_rd_addr  <= '0;
      r_rd_len   <= '0;
    end else begin
      if (w_grant) r_rr_ptr <= w_rr_next;
      if (w_push) begin
        r_rd_valid <= 1'b1;
        r_rd_addr  <= w_grant_addr;
        r_rd_len   <= w_grant_len;
      end else if (dma_rd_ready) begin
        r_rd_valid <= 1'b0;
      end
    end
  end

  // Tag storage needs no reset; occupancy gates every read of it
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_tag_id[r_wr_ptr]  <= w_winner;
      r_tag_len[r_wr_ptr] <= w_grant_len;
    end
  end

  // FIFO pointers, occupancy and beat counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_beat   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
      if (w_accept) r_beat <= w_head_last ? '0 : r_beat + LEN_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_dma_read_arbiter.sv
// tb_dma_read_arbiter
//   Directed scenarios followed by a random phase. Each cycle every DUT
//   output is compared against a reference model. The model holds a queue
//   for the forwarded request, a queue of outstanding {client, len} tags,
//   an integer round-robin pointer and an integer beat count.
module tb_dma_read_arbiter;

  localparam int N   = 4;
  localparam int AWD = 64;
  localparam int LW  = 32;
  localparam int DW  = 512;
  localparam int TD  = 16;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AWD-1:0] req_addr;
  logic [N*LW-1:0] req_len;
  logic            dma_rd_valid;
  logic            dma_rd_ready;
  logic [AWD-1:0]  dma_rd_addr;
  logic [LW-1:0]   dma_rd_len;
  logic            dma_rdata_valid;
  logic            dma_rdata_ready;
  logic [DW-1:0]   dma_rdata;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [DW-1:0]   rsp_data;
  logic            rsp_last;
  logic            busy;

  dma_read_arbiter #(
    .NUM_CLIENTS(N), .ADDR_WIDTH(AWD), .LEN_WIDTH(LW), .DATA_WIDTH(DW), .TAG_DEPTH(TD)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .dma_rd_valid(dma_rd_valid), .dma_rd_ready(dma_rd_ready),
    .dma_rd_addr(dma_rd_addr), .dma_rd_len(dma_rd_len),
    .dma_rdata_valid(dma_rdata_valid), .dma_rdata_ready(dma_rdata_ready), .dma_rdata(dma_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .busy(busy)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard and reference model state
  int checks = 0;
  int errors = 0;
  logic [AWD+LW-1:0] exp_q[$];  // request held in the output stage: {addr, len}
  int tq_id[$];
  int tq_len[$];
  int m_rr   = 0;
  int m_beat = 0;

  // Observations of the DUT taken in the last tick, for directed checks
  int   obs_grant;
  logic [N-1:0] obs_rsp_valid;
  logic obs_rsp_last;
  logic obs_rdata_ready;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: compare at the falling edge, advance the model,
  // then return 1 time unit after the rising edge for the next stimulus.
  task automatic tick();
    int w;
    int hid;
    int hlen;
    logic free;
    logic full;
    logic ne;
    logic [N-1:0] e_rr;
    logic [N-1:0] e_rv;
    logic [AWD-1:0] ga;
    logic [LW-1:0] gl;
    @(negedge clk);
    free = (exp_q.size() == 0) || dma_rd_ready;
    full = (tq_id.size() == TD);
    ne   = (tq_id.size() != 0);
    hid  = ne ? tq_id[0] : 0;
    hlen = ne ? tq_len[0] : 0;
    w = -1;
    if (!reset && free && !full) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_rr + k) % N;
        if (w < 0 && req_valid[idx]) w = idx;
      end
    end
    e_rr = '0;
    if (w >= 0) e_rr[w] = 1'b1;
    e_rv = '0;
    if (!reset && ne && dma_rdata_valid) e_rv[hid] = 1'b1;

    obs_grant = -1;
    for (int k = 0; k < N; k++) if (req_ready[k]) obs_grant = (obs_grant == -1) ? k : -2;
    obs_rsp_valid   = rsp_valid;
    obs_rsp_last    = rsp_last;
    obs_rdata_ready = dma_rdata_ready;

    check("req_ready", req_ready, e_rr);
    check("dma_rd_valid", dma_rd_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check("dma_rd_addr", dma_rd_addr, exp_q[0][AWD+LW-1:LW]);
      check("dma_rd_len", dma_rd_len, exp_q[0][LW-1:0]);
    end
    check("busy", busy, (exp_q.size() != 0) || ne);
    check("dma_rdata_ready", dma_rdata_ready, !reset && ne && rsp_ready[hid]);
    check("rsp_valid", rsp_valid, e_rv);
    check("rsp_last", rsp_last, !reset && ne && (m_beat == hlen - 1));
    if (e_rv != '0) check("rsp_data", rsp_data, dma_rdata);

    if (reset) begin
      exp_q.delete(); tq_id.delete(); tq_len.delete();
      m_rr = 0; m_beat = 0;
    end else begin
      if (ne && dma_rdata_valid && rsp_ready[hid]) begin
        if (m_beat == hlen - 1) begin
          void'(tq_id.pop_front()); void'(tq_len.pop_front());
          m_beat = 0;
        end else begin
          m_beat++;
        end
      end
      if (exp_q.size() != 0 && dma_rd_ready) void'(exp_q.pop_front());
      if (w >= 0) begin
        ga = req_addr[w*AWD +: AWD];
        gl = req_len[w*LW +: LW];
        if (gl != 0) begin
          exp_q.push_back({ga, gl});
          tq_id.push_back(w);
          tq_len.push_back(int'(gl));
        end
        m_rr = (w + 1) % N;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic clear_inputs();
    req_valid = '0; req_addr = '0; req_len = '0;
    dma_rd_ready = 1'b1; dma_rdata_valid = 1'b0; dma_rdata = '0; rsp_ready = '1;
  endtask

  task automatic set_req(input int c, input logic [AWD-1:0] a, input logic [LW-1:0] l);
    req_addr[c*AWD +: AWD] = a;
    req_len[c*LW +: LW]    = l;
  endtask

  task automatic rand_data();
    for (int j = 0; j < DW / 32; j++) dma_rdata[j*32 +: 32] = $urandom();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  int cnt;

  initial begin
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
    check("reset_addr", dma_rd_addr, 64'h0);
    check("reset_len", dma_rd_len, 32'h0);
    check("reset_busy", busy, 1'b0);

    // Single client burst of 3 lines
    set_req(0, 64'h1000, 32'd3);
    req_valid = 4'b0001;
    tick();
    check("t1_grant", obs_grant, 0);
    req_valid = '0;
    tick();
    check("t1_fwd_addr", dma_rd_addr, 64'h1000);
    dma_rdata_valid = 1'b1;
    for (int b = 0; b < 3; b++) begin
      rand_data();
      tick();
      check("t1_rsp_owner", obs_rsp_valid, 4'b0001);
      check("t1_last", obs_rsp_last, b == 2);
    end
    dma_rdata_valid = 1'b0;
    tick();
    check("t1_busy_drop", busy, 1'b0);

    // Round-robin fairness, one grant per cycle
    do_reset();
    for (int c = 0; c < N; c++) set_req(c, 64'h100 * (c + 1), 32'd1);
    req_valid = '1;
    for (int g = 0; g < 6; g++) begin
      tick();
      check("t2_order", obs_grant, g % N);
    end
    clear_inputs();

    // Tag FIFO full
    do_reset();
    set_req(0, 64'h4000, 32'd2);
    req_valid = 4'b0001;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (obs_grant == 0) cnt++;
    end
    check("t3_fill_count", cnt, 16);
    dma_rdata_valid = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      rand_data();
      if (i == 2) dma_rdata_valid = 1'b0;
      tick();
      if (obs_grant == 0) cnt++;
    end
    check("t3_refill_count", cnt, 1);
    clear_inputs();

    // In-order return with the head owner stalled
    do_reset();
    set_req(1, 64'h2000, 32'd2);
    set_req(3, 64'h3000, 32'd1);
    req_valid = 4'b1010;
    tick();
    check("t4_grant1", obs_grant, 1);
    tick();
    check("t4_grant3", obs_grant, 3);
    req_valid = '0;
    rsp_ready = 4'b1101;
    dma_rdata_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rand_data();
      tick();
      check("t4_stall_ready", obs_rdata_ready, 1'b0);
      check("t4_stall_owner", obs_rsp_valid, 4'b0010);
    end
    rsp_ready = '1;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      tick();
    end
    check("t4_c3_owner", obs_rsp_valid, 4'b1000);
    check("t4_c3_last", obs_rsp_last, 1'b1);
    dma_rdata_valid = 1'b0;

    // Zero-length request consumed without forwarding
    set_req(2, 64'h5000, 32'd0);
    req_valid = 4'b0100;
    tick();
    check("t5_len0_grant", obs_grant, 2);
    req_valid = '0;
    tick();
    check("t5_no_fwd", dma_rd_valid, 1'b0);
    for (int c = 0; c < N; c++) set_req(c, 64'h6000, 32'd1);
    req_valid = '1;
    tick();
    check("t5_rr_after_len0", obs_grant, 3);
    clear_inputs();

    // Back-pressure on the forwarded request, then reset mid-burst
    do_reset();
    dma_rd_ready = 1'b0;
    set_req(0, 64'hABC0, 32'd5);
    set_req(1, 64'hDEF0, 32'd1);
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t6_no_grant", obs_grant, -1);
      check("t6_addr_hold", dma_rd_addr, 64'hABC0);
    end
    req_valid = '0;
    dma_rd_ready = 1'b1;
    tick();
    dma_rdata_valid = 1'b1;
    rand_data(); tick();
    rand_data(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("t6_rst_ready", obs_rdata_ready, 1'b0);
    check("t6_rst_valid", dma_rd_valid, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    clear_inputs();

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      req_valid = N'($urandom_range(0, (1 << N) - 1));
      for (int c = 0; c < N; c++)
        set_req(c, {$urandom(), $urandom()}, LW'($urandom_range(0, 3)));
      dma_rd_ready    = ($urandom_range(0, 3) != 0);
      dma_rdata_valid = $urandom_range(0, 1) == 1;
      rsp_ready       = N'($urandom_range(0, (1 << N) - 1));
      rand_data();
      tick();
    end

    // Drain within a bounded number of cycles
    clear_inputs();
    dma_rdata_valid = 1'b1;
    for (int i = 0; i < 200 && (tq_id.size() != 0 || exp_q.size() != 0); i++) begin
      rand_data();
      tick();
    end
    dma_rdata_valid = 1'b0;
    tick();
    check("drain_busy", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
